sorted_pkt_checker: RTL and testbench



---
 rtl/sorted_pkt_checker.sv | 181 ++++++++++++++++++
 tb/tb_sorted_pkt_checker.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sorted_pkt_checker.sv
// Avalon-ST packet sink that checks ordering, framing and length of every packet.
// Optional SORTED_PKT_CHECKER_THROTTLE_EN adds LFSR-driven pseudo-random backpressure.
module sorted_pkt_checker #(
  parameter int DWIDTH      = 8,
  parameter int MAX_PKT_LEN = 256,
  parameter int LEN_W       = $clog2(MAX_PKT_LEN + 1)
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DWIDTH-1:0] snk_data_i,
  input  logic              snk_startofpacket_i,
  input  logic              snk_endofpacket_i,
  input  logic              snk_valid_i,
  output logic              snk_ready_o,
  input  logic [LEN_W-1:0]  exp_len_i,
  output logic              pkt_done_o,
  output logic              pkt_ok_o,
  output logic              err_order_o,
  output logic              err_framing_o,
  output logic              err_len_o,
  output logic [LEN_W-1:0]  pkt_len_o,
  output logic [15:0]       pkt_cnt_o,
  output logic [15:0]       err_cnt_o
);

  typedef enum logic [1:0] {IDLE, RECV, REPORT} state_e;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PKT_LEN);

  state_e            state_q, state_d;
  logic [DWIDTH-1:0] prev_q, prev_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  exp_q, exp_d;
  logic              order_q, order_d;
  logic              framing_q, framing_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic              ok_q, ok_d;
  logic              err_order_q, err_order_d;
  logic              err_framing_q, err_framing_d;
  logic              err_len_q, err_len_d;
  logic [LEN_W-1:0]  pkt_len_q, pkt_len_d;
  logic [15:0]       pkt_cnt_q, pkt_cnt_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic              beat;
  logic              finish;
  logic              len_bad;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

`ifdef SORTED_PKT_CHECKER_THROTTLE_EN
  logic [15:0] lfsr_q, lfsr_d;
  assign lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign snk_ready_o = !srst_i && (state_q != REPORT) && lfsr_q[0];
`else
  assign snk_ready_o = !srst_i && (state_q != REPORT);
`endif

  assign beat = snk_valid_i && snk_ready_o;

  // NOTE: every _d gets a default at the top so no path through the case leaves a latch.
  always_comb begin
    state_d       = state_q;
    prev_d        = prev_q;
    len_d         = len_q;
    exp_d         = exp_q;
    order_d       = order_q;
    framing_d     = framing_q;
    ovf_d         = ovf_q;
    pkt_cnt_d     = pkt_cnt_q;
    err_cnt_d     = err_cnt_q;
    done_d        = 1'b0;
    ok_d          = 1'b0;
    err_order_d   = 1'b0;
    err_framing_d = 1'b0;
    err_len_d     = 1'b0;
    pkt_len_d     = '0;
    finish        = 1'b0;
    len_bad       = 1'b0;

    case (state_q)
      IDLE: begin
        if (beat) begin
          if (snk_startofpacket_i) begin
            prev_d    = snk_data_i;
            len_d     = LEN_W'(1);
            exp_d     = exp_len_i;
            order_d   = 1'b0;
            framing_d = 1'b0;
            ovf_d     = 1'b0;
            finish    = snk_endofpacket_i;
            state_d   = snk_endofpacket_i ? REPORT : RECV;
          end else begin
            err_cnt_d = sat_inc(err_cnt_q);
          end
        end
      end
      RECV: begin
        if (beat) begin
          order_d   = order_q | (snk_data_i < prev_q);
          framing_d = framing_q | snk_startofpacket_i;
          ovf_d     = ovf_q | (len_q == MAX_LEN);
          len_d     = (len_q == MAX_LEN) ? len_q : len_q + LEN_W'(1);
          prev_d    = snk_data_i;
          finish    = snk_endofpacket_i;
          if (snk_endofpacket_i) state_d = REPORT;
        end
      end
      default: state_d = IDLE;
    endcase

    // Status is computed from the post-beat values so it is registered into the REPORT cycle.
    if (finish) begin
      len_bad       = ovf_d || (len_d != exp_d);
      done_d        = 1'b1;
      ok_d          = !order_d && !framing_d && !len_bad;
      err_order_d   = order_d;
      err_framing_d = framing_d;
      err_len_d     = len_bad;
      pkt_len_d     = len_d;
      pkt_cnt_d     = sat_inc(pkt_cnt_q);
      if (!ok_d) err_cnt_d = sat_inc(err_cnt_q);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q       <= IDLE;
      prev_q        <= '0;
      len_q         <= '0;
      exp_q         <= '0;
      order_q       <= 1'b0;
      framing_q     <= 1'b0;
      ovf_q         <= 1'b0;
      done_q        <= 1'b0;
      ok_q          <= 1'b0;
      err_order_q   <= 1'b0;
      err_framing_q <= 1'b0;
      err_len_q     <= 1'b0;
      pkt_len_q     <= '0;
      pkt_cnt_q     <= '0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      len_q         <= len_d;
      exp_q         <= exp_d;
      order_q       <= order_d;
      framing_q     <= framing_d;
      ovf_q         <= ovf_d;
      done_q        <= done_d;
      ok_q          <= ok_d;
      err_order_q   <= err_order_d;
      err_framing_q <= err_framing_d;
      err_len_q     <= err_len_d;
      pkt_len_q     <= pkt_len_d;
      pkt_cnt_q     <= pkt_cnt_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

`ifdef SORTED_PKT_CHECKER_THROTTLE_EN
  always_ff @(posedge clk_i) begin
    if (srst_i) lfsr_q <= 16'hACE1;
    else        lfsr_q <= lfsr_d;
  end
`endif

  assign pkt_done_o    = done_q;
  assign pkt_ok_o      = ok_q;
  assign err_order_o   = err_order_q;
  assign err_framing_o = err_framing_q;
  assign err_len_o     = err_len_q;
  assign pkt_len_o     = pkt_len_q;
  assign pkt_cnt_o     = pkt_cnt_q;
  assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_sorted_pkt_checker.sv
// Directed scoreboard bench for sorted_pkt_checker; the throttle section runs when
// SORTED_PKT_CHECKER_THROTTLE_EN is defined for the whole build.
module tb_sorted_pkt_checker;

  localparam int LEN_W = 9;

  typedef struct packed {
    logic             ok;
    logic             eo;
    logic             ef;
    logic             el;
    logic [LEN_W-1:0] len;
  } exp_t;

  logic             clk_i = 1'b0;
  logic             srst_i;
  logic [7:0]       snk_data_i;
  logic             snk_startofpacket_i;
  logic             snk_endofpacket_i;
  logic             snk_valid_i;
  logic             snk_ready_o;
  logic [LEN_W-1:0] exp_len_i;
  logic             pkt_done_o;
  logic             pkt_ok_o;
  logic             err_order_o;
  logic             err_framing_o;
  logic             err_len_o;
  logic [LEN_W-1:0] pkt_len_o;
  logic [15:0]      pkt_cnt_o;
  logic [15:0]      err_cnt_o;

  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;
  exp_t sb[$];
  int   exp_pkts = 0;
  int   exp_errs = 0;
  int   stall_cycles = 0;

  sorted_pkt_checker dut (
    .clk_i(clk_i), .srst_i(srst_i), .snk_data_i(snk_data_i),
    .snk_startofpacket_i(snk_startofpacket_i), .snk_endofpacket_i(snk_endofpacket_i),
    .snk_valid_i(snk_valid_i), .snk_ready_o(snk_ready_o), .exp_len_i(exp_len_i),
    .pkt_done_o(pkt_done_o), .pkt_ok_o(pkt_ok_o), .err_order_o(err_order_o),
    .err_framing_o(err_framing_o), .err_len_o(err_len_o), .pkt_len_o(pkt_len_o),
    .pkt_cnt_o(pkt_cnt_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard side: every strobe pops one expectation; qualifiers must be 0 otherwise.
  always @(negedge clk_i) begin
    if (mon_en) begin
      if (pkt_done_o) begin
        if (sb.size() == 0) begin
          check("unexpected_strobe", sb.size(), 1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("pkt_ok", pkt_ok_o, e.ok);
          check("err_order", err_order_o, e.eo);
          check("err_framing", err_framing_o, e.ef);
          check("err_len", err_len_o, e.el);
          check("pkt_len", pkt_len_o, e.len);
        end
      end else begin
        check("quals_idle", {pkt_ok_o, err_order_o, err_framing_o, err_len_o, pkt_len_o}, 0);
      end
    end
  end

  task automatic send_beat(input logic [7:0] d, input logic sop, input logic eop,
                           input logic [LEN_W-1:0] el);
    int w;
    w = 0;
    @(negedge clk_i);
    snk_data_i          = d;
    snk_startofpacket_i = sop;
    snk_endofpacket_i   = eop;
    exp_len_i           = el;
    snk_valid_i         = 1'b1;
    while (!snk_ready_o && w < 2000) begin
      @(negedge clk_i);
      w++;
      stall_cycles++;
    end
    if (w >= 2000) check("ready_timeout", w, 0);
    @(posedge clk_i);
    #1;
    snk_valid_i = 1'b0;
  endtask

  task automatic expect_pkt(input logic ok, input logic eo, input logic ef, input logic el,
                            input logic [LEN_W-1:0] len);
    exp_t e;
    e = '{ok: ok, eo: eo, ef: ef, el: el, len: len};
    sb.push_back(e);
    exp_pkts++;
    if (!ok) exp_errs++;
  endtask

  task automatic check_counters(input string tag);
    @(negedge clk_i);
    @(negedge clk_i);
    check({tag, "_pkt_cnt"}, pkt_cnt_o, exp_pkts);
    check({tag, "_err_cnt"}, err_cnt_o, exp_errs);
  endtask

  initial begin
    logic [7:0] v;
    int         n;
    srst_i = 1'b1;
    snk_valid_i = 1'b0;
    snk_data_i = '0;
    snk_startofpacket_i = 1'b0;
    snk_endofpacket_i = 1'b0;
    exp_len_i = '0;
    repeat (3) @(negedge clk_i);
    mon_en = 1'b1;
    check("rst_ready", snk_ready_o, 0);
    check("rst_done", pkt_done_o, 0);
    check("rst_cnts", {pkt_cnt_o, err_cnt_o}, 0);
    srst_i = 1'b0;
    @(negedge clk_i);
`ifndef SORTED_PKT_CHECKER_THROTTLE_EN
    check("ready_after_rst", snk_ready_o, 1);
`endif

    // Sorted packet with repeats.
    expect_pkt(1, 0, 0, 0, 5);
    send_beat(1, 1, 0, 5); send_beat(2, 0, 0, 5); send_beat(2, 0, 0, 5);
    send_beat(5, 0, 0, 5); send_beat(9, 0, 1, 5);
    check_counters("sorted");

    // Out-of-order beat.
    expect_pkt(0, 1, 0, 0, 3);
    send_beat(3, 1, 0, 3); send_beat(7, 0, 0, 3); send_beat(4, 0, 1, 3);
    check_counters("unsorted");

    // Short packet, then a single-beat packet.
    expect_pkt(0, 0, 0, 1, 4);
    send_beat(1, 1, 0, 6); send_beat(2, 0, 0, 6); send_beat(3, 0, 0, 6); send_beat(4, 0, 1, 6);
    expect_pkt(1, 0, 0, 0, 1);
    send_beat(8'hFF, 1, 1, 1);
    check_counters("len_single");

    // Mid-packet sop, then an orphan beat in IDLE.
    expect_pkt(0, 0, 1, 0, 4);
    send_beat(1, 1, 0, 4); send_beat(2, 0, 0, 4); send_beat(3, 1, 0, 4); send_beat(4, 0, 1, 4);
    check_counters("framing");
    send_beat(8'h11, 0, 0, 4);
    exp_errs++;
    check_counters("orphan");

    // Expected length 0 can never pass.
    expect_pkt(0, 0, 0, 1, 1);
    send_beat(8'h20, 1, 1, 0);
    check_counters("exp0");

    // 257 beats with exp=256: length saturates at 256 and flags overflow.
    expect_pkt(0, 0, 0, 1, 256);
    for (int i = 0; i < 257; i++) send_beat(0, i == 0, i == 256, 256);
    check_counters("overflow");

    // Reset mid-packet: no strobe, counters cleared.
    send_beat(1, 1, 0, 8); send_beat(2, 0, 0, 8); send_beat(3, 0, 0, 8);
    @(negedge clk_i);
    srst_i = 1'b1;
    @(negedge clk_i);
    check("midrst_ready", snk_ready_o, 0);
    @(negedge clk_i);
    srst_i = 1'b0;
    @(negedge clk_i);
    exp_pkts = 0;
    exp_errs = 0;
`ifndef SORTED_PKT_CHECKER_THROTTLE_EN
    check("midrst_ready_after", snk_ready_o, 1);
`endif
    check("midrst_pkt_cnt", pkt_cnt_o, exp_pkts);
    check("midrst_err_cnt", err_cnt_o, exp_errs);

    // Recovery after reset.
    expect_pkt(1, 0, 0, 0, 2);
    send_beat(4, 1, 0, 2); send_beat(4, 0, 1, 2);
    check_counters("recover");

`ifdef SORTED_PKT_CHECKER_THROTTLE_EN
    stall_cycles = 0;
    for (int p = 0; p < 100; p++) begin
      n = $urandom_range(1, 256);
      v = 8'($urandom_range(0, 15));
      expect_pkt(1, 0, 0, 0, LEN_W'(n));
      for (int i = 0; i < n; i++) begin
        send_beat(v, i == 0, i == n - 1, LEN_W'(n));
        if (v < 8'd255 && $urandom_range(0, 3) == 0) v = v + 8'd1;
      end
    end
    check_counters("throttle");
    check("throttle_stalled", stall_cycles > 100, 1);
`endif

    begin
      int w;
      w = 0;
      while (sb.size() != 0 && w < 100) begin
        @(negedge clk_i);
        w++;
      end
      check("sb_drained", sb.size(), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
